controlador_display_bcd: RTL and testbench
==========================================

// Module: controlador_display_bcd
// PURPOSE
//  Sequences the 4-digit multiplexed 7-segment display of the scale from a 16-bit 8.8 BCD weight (II.FF).
//  Accepts a new weight via valid/ready into a one-deep pending buffer and swaps it in only at frame boundaries (no tearing).
//  Scans digits with a prescaled tick and drives the anode, nibble and decimal-point outputs.
//  Sits between the weight/price BCD datapath and the shared BCD-to-7-segment decoder.
// PARAMETERS
//  PRESCALE  50000  clk cycles per digit slot; legal range >= 2
// PORTS
//  clk           in   1   system clock, all logic on rising edge
//  rst           in   1   synchronous reset, active-high
//  bcd_valid     in   1   bcd_total holds a new weight this cycle
//  bcd_total     in   16  BCD 8.8: [15:12] tens, [11:8] units, [7:4] tenths, [3:0] hundredths
//  bcd_ready     out  1   block can accept bcd_total this cycle
//  an            out  4   digit anodes, active-low, an[3] = tens ... an[0] = hundredths
//  digito        out  4   BCD nibble of the active digit, to the segment decoder
//  dp            out  1   decimal point, active-low
//  frame_done    out  1   one-cycle pulse when a full 4-digit scan completes
//  err_bcd       out  1   sticky: an accepted nibble was > 9
// BEHAVIOUR
//  - Clock and reset: one clock, clk. Reset rst is synchronous and active-high. All outputs are registered.
//  - Reset values: an=4'b1111, digito=0, dp=1, bcd_ready=1, frame_done=0, err_bcd=0.
//  - Reset also clears the state to S_IDLE, the prescaler to 0, and the display and pending registers to 0 (pending empty).
//  - Accept: a transfer occurs when bcd_valid && bcd_ready.
//  - bcd_ready = !pending_full, except in S_IDLE, where it is always 1.
//  - Prescaler: counts 0..PRESCALE-1 and wraps. tick = (cnt == PRESCALE-1).
//  - The prescaler is held at 0 in S_IDLE and cleared on leaving S_IDLE.
//  - FSM: S_IDLE -> S_D3 -> S_D2 -> S_D1 -> S_D0 -> S_D3 ...
//  - Each S_Dx -> next transition happens on tick only. The frame boundary is tick in S_D0.
//  - S_IDLE: display blank (an=1111). An accept writes bcd_total directly into the display register.
//    The FSM enters S_D3 the next cycle; pending stays empty.
//  - S_Dx: an has bit x low and all other bits high; digito = display nibble x.
//  - dp=0 only in S_D2 (after units); dp=1 otherwise.
//  - Leading-zero blanking: in S_D3, if tens nibble == 0 then an=1111. The slot time is still consumed.
//  - Accept while in S_Dx: bcd_total goes into pending, pending_full=1, and bcd_ready drops next cycle.
//  - Frame boundary:
//    - If pending_full: display <= pending, pending_full <= 0.
//    - Else if an accept occurs in that same cycle: display <= bcd_total directly (bypass); pending stays empty.
//    - Else: display is unchanged.
//  - frame_done = 1 for exactly the cycle after the frame boundary.
//  - Latency: data accepted mid-frame is first shown at the next S_D3.
//    Worst case is 4*PRESCALE cycles; it is never shown mid-frame.
//  - Pending full: new valids are stalled (ready=0) and nothing is overwritten.
//    The stall lasts until the next frame boundary.
//  - Invalid BCD: any accepted nibble > 9 sets err_bcd, which holds until rst.
//    The nibble is passed unchanged to digito; the decoder blanks it.
//  - Reset mid-frame: the next cycle shows reset values. Pending data is discarded.
//    The display stays blank until a new accept.
//  - Output timing: outputs update on the same edge as the state change.
//    No overlap cycles: exactly one anode low, or none.
// TESTING (PRESCALE=4)
//  - rst, then idle 20 cycles -> an=1111 held, bcd_ready=1, frame_done never pulses.
//  - Accept 16'h1234 in idle -> next cycle an=0111 with digito=1.
//    Then an=1011/digito=2/dp=0, then an=1101/digito=3, then an=1110/digito=4, 4 cycles each.
//    Then a frame_done pulse.
//  - Accept 16'h0567 -> the S_D3 slot shows an=1111 for 4 cycles, then digits 5,6,7 as normal.
//  - Mid-frame, accept 16'h1111 then hold valid with 16'h2222 -> ready=0 until the boundary.
//    The next frame shows 1111; 2222 is accepted at the boundary and shown in the following frame.
//  - Accept at the exact boundary cycle with pending empty -> shown in the immediately next S_D3 (bypass).
//  - Accept 16'h12A4 -> err_bcd=1 from the next cycle. Assert rst mid-S_D1 -> all outputs at reset values next cycle and err_bcd=0.

Source files
------------

// File: rtl/controlador_display_bcd.sv
// Display sequencer for the scale's 4-digit multiplexed 7-segment readout.
// Takes a BCD 8.8 weight (II.FF) over valid/ready into a one-deep pending
// buffer and swaps it into the display only at frame boundaries, so a frame
// never shows digits from two different weights.
module controlador_display_bcd #(
    parameter int PRESCALE = 50000
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        bcd_valid,
    input  logic [15:0] bcd_total,
    output logic        bcd_ready,
    output logic [3:0]  an,
    output logic [3:0]  digito,
    output logic        dp,
    output logic        frame_done,
    output logic        err_bcd
);

    localparam int CNT_W = (PRESCALE > 2) ? $clog2(PRESCALE) : 1;
    localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(PRESCALE - 1);

    typedef enum logic [2:0] {
        S_IDLE,
        S_D3,
        S_D2,
        S_D1,
        S_D0
    } state_t;

    state_t           state, state_next;
    logic [CNT_W-1:0] cnt, cnt_next;
    logic [15:0]      display, display_next;
    logic [15:0]      pending, pending_next;
    logic             pending_full, pending_full_next;

    logic             accept;
    logic             tick;
    logic             boundary;

    logic [3:0]       an_next;
    logic [3:0]       digito_next;
    logic             dp_next;
    logic             ready_next;
    logic             err_next;

    // True when any of the four nibbles is not a decimal digit.
    function automatic logic bcd_invalid(input logic [15:0] v);
        return (v[15:12] > 4'd9) || (v[11:8] > 4'd9) ||
               (v[7:4]   > 4'd9) || (v[3:0]  > 4'd9);
    endfunction

    // Nibble of the display word belonging to the digit slot of a state.
    function automatic logic [3:0] slot_nibble(input logic [15:0] v, input state_t s);
        case (s)
            S_D3:    return v[15:12];
            S_D2:    return v[11:8];
            S_D1:    return v[7:4];
            S_D0:    return v[3:0];
            default: return 4'd0;
        endcase
    endfunction

    assign accept   = bcd_valid && bcd_ready;
    assign tick     = (state != S_IDLE) && (cnt == CNT_MAX);
    assign boundary = tick && (state == S_D0);

    // Next-state, prescaler, display/pending buffer and next output values.
    always_comb begin
        state_next        = state;
        cnt_next          = cnt;
        display_next      = display;
        pending_next      = pending;
        pending_full_next = pending_full;

        case (state)
            S_IDLE: begin
                cnt_next = '0;
                if (accept) begin
                    display_next = bcd_total;
                    state_next   = S_D3;
                end
            end
            default: begin
                cnt_next = tick ? '0 : cnt + CNT_W'(1);
                if (tick) begin
                    case (state)
                        S_D3:    state_next = S_D2;
                        S_D2:    state_next = S_D1;
                        S_D1:    state_next = S_D0;
                        default: state_next = S_D3;
                    endcase
                end
                if (boundary) begin
                    // Pending data wins; otherwise a same-cycle accept bypasses the buffer.
                    if (pending_full) begin
                        display_next      = pending;
                        pending_full_next = 1'b0;
                    end else if (accept) begin
                        display_next = bcd_total;
                    end
                end else if (accept) begin
                    pending_next      = bcd_total;
                    pending_full_next = 1'b1;
                end
            end
        endcase

        // Outputs are computed from the next state so they change on the same edge.
        an_next = 4'b1111;
        case (state_next)
            S_D3:    an_next = (display_next[15:12] == 4'd0) ? 4'b1111 : 4'b0111;
            S_D2:    an_next = 4'b1011;
            S_D1:    an_next = 4'b1101;
            S_D0:    an_next = 4'b1110;
            default: an_next = 4'b1111;
        endcase
        digito_next = slot_nibble(display_next, state_next);
        dp_next     = (state_next != S_D2);
        ready_next  = (state_next == S_IDLE) ? 1'b1 : !pending_full_next;
        err_next    = err_bcd || (accept && bcd_invalid(bcd_total));
    end

    // State, prescaler and data buffers.
    always_ff @(posedge clk) begin
        if (rst) begin
            state        <= S_IDLE;
            cnt          <= '0;
            display      <= '0;
            pending      <= '0;
            pending_full <= 1'b0;
        end else begin
            state        <= state_next;
            cnt          <= cnt_next;
            display      <= display_next;
            pending      <= pending_next;
            pending_full <= pending_full_next;
        end
    end

    // Registered outputs.
    always_ff @(posedge clk) begin
        if (rst) begin
            an         <= 4'b1111;
            digito     <= 4'd0;
            dp         <= 1'b1;
            bcd_ready  <= 1'b1;
            frame_done <= 1'b0;
            err_bcd    <= 1'b0;
        end else begin
            an         <= an_next;
            digito     <= digito_next;
            dp         <= dp_next;
            bcd_ready  <= ready_next;
            frame_done <= boundary;
            err_bcd    <= err_next;
        end
    end

endmodule

// File: tb/tb_controlador_display_bcd.sv
// Directed bench for controlador_display_bcd with PRESCALE=4.
module tb_controlador_display_bcd;

    logic        clk;
    logic        rst;
    logic        bcd_valid;
    logic [15:0] bcd_total;
    logic        bcd_ready;
    logic [3:0]  an;
    logic [3:0]  digito;
    logic        dp;
    logic        frame_done;
    logic        err_bcd;

    int tests;
    int failures;

    controlador_display_bcd #(.PRESCALE(4)) dut (
        .clk        (clk),
        .rst        (rst),
        .bcd_valid  (bcd_valid),
        .bcd_total  (bcd_total),
        .bcd_ready  (bcd_ready),
        .an         (an),
        .digito     (digito),
        .dp         (dp),
        .frame_done (frame_done),
        .err_bcd    (err_bcd)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Advance one clock and settle just after the edge.
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [15:0] observed, input logic [15:0] expected);
        tests++;
        assert (observed === expected) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, observed, expected);
        end
    endtask

    // Check one full 4-cycle digit slot, leaving the bench at the start of the next slot.
    task automatic check_slot(input string tag, input logic [3:0] e_an, input logic [3:0] e_dig,
                              input logic e_dp);
        for (int i = 0; i < 4; i++) begin
            chk({tag, "_an"}, 16'(an), 16'(e_an));
            chk({tag, "_dig"}, 16'(digito), 16'(e_dig));
            chk({tag, "_dp"}, 16'(dp), 16'(e_dp));
            step();
        end
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog observed=timeout expected=finish");
        $fatal(1, "timeout");
    end

    initial begin
        tests     = 0;
        failures  = 0;
        rst       = 1'b1;
        bcd_valid = 1'b0;
        bcd_total = 16'h0000;
        step();
        step();
        rst = 1'b0;

        // Reset values
        chk("rst_an", 16'(an), 16'hF);
        chk("rst_dig", 16'(digito), 16'h0);
        chk("rst_dp", 16'(dp), 16'h1);
        chk("rst_ready", 16'(bcd_ready), 16'h1);
        chk("rst_fd", 16'(frame_done), 16'h0);
        chk("rst_err", 16'(err_bcd), 16'h0);

        // Idle: blank, ready, no frame pulses
        for (int i = 0; i < 20; i++) begin
            step();
            chk("idle_an", 16'(an), 16'hF);
            chk("idle_ready", 16'(bcd_ready), 16'h1);
            chk("idle_fd", 16'(frame_done), 16'h0);
        end

        // Accept 1234 in idle: shown from the next cycle
        bcd_valid = 1'b1;
        bcd_total = 16'h1234;
        step();
        bcd_valid = 1'b0;
        chk("f1_fd0", 16'(frame_done), 16'h0);
        chk("f1_ready", 16'(bcd_ready), 16'h1);
        check_slot("f1_d3", 4'b0111, 4'd1, 1'b1);
        check_slot("f1_d2", 4'b1011, 4'd2, 1'b0);
        check_slot("f1_d1", 4'b1101, 4'd3, 1'b1);
        check_slot("f1_d0", 4'b1110, 4'd4, 1'b1);
        chk("f1_done", 16'(frame_done), 16'h1);

        // Mid-frame accept of 0567 goes to pending; 1234 keeps showing
        bcd_valid = 1'b1;
        bcd_total = 16'h0567;
        step();
        bcd_valid = 1'b0;
        chk("p1_ready_low", 16'(bcd_ready), 16'h0);
        chk("p1_fd_pulse_once", 16'(frame_done), 16'h0);
        chk("p1_still_1234", 16'(digito), 16'h1);
        for (int i = 0; i < 15; i++) step();
        chk("f3_done", 16'(frame_done), 16'h1);
        chk("f3_ready", 16'(bcd_ready), 16'h1);
        check_slot("f3_d3_blank", 4'b1111, 4'd0, 1'b1);
        check_slot("f3_d2", 4'b1011, 4'd5, 1'b0);
        check_slot("f3_d1", 4'b1101, 4'd6, 1'b1);
        check_slot("f3_d0", 4'b1110, 4'd7, 1'b1);

        // Stall: 1111 fills pending, 2222 held with valid until room appears
        bcd_valid = 1'b1;
        bcd_total = 16'h1111;
        step();
        bcd_total = 16'h2222;
        for (int i = 0; i < 15; i++) begin
            chk("stall_ready", 16'(bcd_ready), 16'h0);
            step();
        end
        chk("f5_done", 16'(frame_done), 16'h1);
        chk("f5_ready", 16'(bcd_ready), 16'h1);
        chk("f5_an", 16'(an), 16'h7);
        chk("f5_dig", 16'(digito), 16'h1);
        step();
        bcd_valid = 1'b0;
        chk("f5_ready_after_2222", 16'(bcd_ready), 16'h0);
        for (int i = 0; i < 3; i++) begin
            chk("f5_d3_dig", 16'(digito), 16'h1);
            step();
        end
        check_slot("f5_d2", 4'b1011, 4'd1, 1'b0);
        check_slot("f5_d1", 4'b1101, 4'd1, 1'b1);
        check_slot("f5_d0", 4'b1110, 4'd1, 1'b1);
        check_slot("f6_d3", 4'b0111, 4'd2, 1'b1);
        check_slot("f6_d2", 4'b1011, 4'd2, 1'b0);
        check_slot("f6_d1", 4'b1101, 4'd2, 1'b1);
        check_slot("f6_d0", 4'b1110, 4'd2, 1'b1);

        // Bypass: accept exactly on the boundary cycle with pending empty
        for (int i = 0; i < 15; i++) step();
        chk("byp_ready", 16'(bcd_ready), 16'h1);
        chk("byp_in_d0", 16'(an), 16'hE);
        bcd_valid = 1'b1;
        bcd_total = 16'h8899;
        step();
        bcd_valid = 1'b0;
        chk("byp_done", 16'(frame_done), 16'h1);
        chk("byp_ready_after", 16'(bcd_ready), 16'h1);
        check_slot("byp_d3", 4'b0111, 4'd8, 1'b1);
        check_slot("byp_d2", 4'b1011, 4'd8, 1'b0);
        check_slot("byp_d1", 4'b1101, 4'd9, 1'b1);
        check_slot("byp_d0", 4'b1110, 4'd9, 1'b1);

        // Invalid BCD sets the sticky error, then reset mid-D1 clears everything
        chk("err_before", 16'(err_bcd), 16'h0);
        bcd_valid = 1'b1;
        bcd_total = 16'h12A4;
        step();
        bcd_valid = 1'b0;
        chk("err_set", 16'(err_bcd), 16'h1);
        for (int i = 0; i < 8; i++) step();
        chk("err_held", 16'(err_bcd), 16'h1);
        chk("mid_d1_an", 16'(an), 16'hD);
        rst = 1'b1;
        step();
        rst = 1'b0;
        chk("rst2_an", 16'(an), 16'hF);
        chk("rst2_dig", 16'(digito), 16'h0);
        chk("rst2_dp", 16'(dp), 16'h1);
        chk("rst2_ready", 16'(bcd_ready), 16'h1);
        chk("rst2_fd", 16'(frame_done), 16'h0);
        chk("rst2_err", 16'(err_bcd), 16'h0);
        for (int i = 0; i < 8; i++) begin
            step();
            chk("rst2_blank", 16'(an), 16'hF);
            chk("rst2_no_fd", 16'(frame_done), 16'h0);
        end

        $display("[TB] %0d tests run, %0d failed", tests, failures);
        $finish;
    end

endmodule
